// File: rtl/riscv_pkg.sv
// Shared pipeline definitions: opcode constants, hazard FSM state encoding
// and the control bundle driven by the hazard unit.
package riscv_pkg;

  localparam logic [6:0] OP_NOP = 7'b0000000;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_HOLD  = 2'd2
  } hz_state_e;

  typedef struct packed {
    logic pc_write;
    logic if_id_write;
    logic control_sel;
    logic if_id_flush;
  } hz_ctrl_t;

  localparam hz_ctrl_t CTRL_NORMAL = '{pc_write: 1'b1, if_id_write: 1'b1,
                                       control_sel: 1'b0, if_id_flush: 1'b0};
  localparam hz_ctrl_t CTRL_FREEZE = '{pc_write: 1'b0, if_id_write: 1'b0,
                                       control_sel: 1'b0, if_id_flush: 1'b0};
  localparam hz_ctrl_t CTRL_BUBBLE = '{pc_write: 1'b0, if_id_write: 1'b0,
                                       control_sel: 1'b1, if_id_flush: 1'b0};
  localparam hz_ctrl_t CTRL_FLUSH  = '{pc_write: 1'b1, if_id_write: 1'b1,
                                       control_sel: 1'b1, if_id_flush: 1'b1};

  // x0 never carries a dependency, so a load targeting it is harmless.
  function automatic logic reg_match(input logic [4:0] rd, input logic [4:0] rs,
                                     input logic used);
    return used && (rd != 5'd0) && (rd == rs);
  endfunction

endpackage

// File: rtl/reg_use_decode.sv
// Opcode decode telling the hazard unit which source register fields of the
// IF/ID instruction are actually read.
module reg_use_decode
  import riscv_pkg::*;
(
  input  logic [6:0] opcode,
  output logic       use_rs1,
  output logic       use_rs2
);

  always_comb begin
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    case (opcode)
      OP_R, OP_SW, OP_BEQ: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
      end
      OP_I, OP_LW: begin
        use_rs1 = 1'b1;
      end
      default: begin
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard unit: load-use stall, taken-branch flush, memory-busy hold.
// Optional performance counters are built when HAZARD_PERF_CNT_EN is defined.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_RUN   | normal issue; detect branch flush and load-use hazards
// ST_STALL | second cycle of a load-use stall; detection suppressed
// ST_HOLD  | memory busy; pipeline frozen, prior state kept in saved_q
module hazard_unit
  import riscv_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [6:0]  id_opcode,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        ex_memread,
  input  logic [4:0]  ex_rd,
  input  logic        ex_branch_taken,
  input  logic        mem_busy,
  output logic        pc_write,
  output logic        if_id_write,
  output logic        control_sel,
  output logic        if_id_flush,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt
);

  logic      use_rs1;
  logic      use_rs2;
  logic      load_use;
  hz_state_e state_q;
  hz_state_e state_d;
  hz_state_e saved_q;
  hz_state_e saved_d;
  hz_state_e eff_state;
  hz_ctrl_t  ctrl;

  reg_use_decode u_reg_use_decode (
    .opcode  (id_opcode),
    .use_rs1 (use_rs1),
    .use_rs2 (use_rs2)
  );

  assign load_use = ex_memread &&
                    (reg_match(ex_rd, id_rs1, use_rs1) ||
                     reg_match(ex_rd, id_rs2, use_rs2));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_RUN;
      saved_q <= ST_RUN;
    end else begin
      state_q <= state_d;
      saved_q <= saved_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    saved_d   = saved_q;
    ctrl      = CTRL_NORMAL;
    // Leaving HOLD behaves exactly like the remembered state in the same cycle.
    eff_state = (state_q == ST_HOLD) ? saved_q : state_q;
    if (reset) begin
      state_d = ST_RUN;
      saved_d = ST_RUN;
      ctrl    = CTRL_NORMAL;
    end else if (mem_busy) begin
      ctrl    = CTRL_FREEZE;
      state_d = ST_HOLD;
      if (state_q != ST_HOLD) begin
        saved_d = state_q;
      end
    end else begin
      case (eff_state)
        ST_STALL: begin
          ctrl    = ex_branch_taken ? CTRL_FLUSH : CTRL_NORMAL;
          state_d = ST_RUN;
        end
        default: begin
          if (ex_branch_taken) begin
            ctrl    = CTRL_FLUSH;
            state_d = ST_RUN;
          end else if (load_use) begin
            ctrl    = CTRL_BUBBLE;
            state_d = ST_STALL;
          end else begin
            ctrl    = CTRL_NORMAL;
            state_d = ST_RUN;
          end
        end
      endcase
    end
  end

  assign pc_write    = ctrl.pc_write;
  assign if_id_write = ctrl.if_id_write;
  assign control_sel = ctrl.control_sel;
  assign if_id_flush = ctrl.if_id_flush;

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_q;
  logic [31:0] flush_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_q <= 32'd0;
      flush_q <= 32'd0;
    end else begin
      if (!ctrl.pc_write) begin
        stall_q <= stall_q + 32'd1;
      end
      if (ctrl.if_id_flush) begin
        flush_q <= flush_q + 32'd1;
      end
    end
  end

  assign stall_cnt = stall_q;
  assign flush_cnt = flush_q;
`else
  assign stall_cnt = 32'd0;
  assign flush_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit: vector table, directed corner
// sequences and randomized traffic against a pending-stall reference model.
module tb_hazard_unit;
  import riscv_pkg::*;

`ifdef HAZARD_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [6:0]  id_opcode = OP_NOP;
  logic [4:0]  id_rs1 = '0;
  logic [4:0]  id_rs2 = '0;
  logic        ex_memread = 1'b0;
  logic [4:0]  ex_rd = '0;
  logic        ex_branch_taken = 1'b0;
  logic        mem_busy = 1'b0;
  logic        pc_write;
  logic        if_id_write;
  logic        control_sel;
  logic        if_id_flush;
  logic [31:0] stall_cnt;
  logic [31:0] flush_cnt;

  int ncmp = 0;
  int nerr = 0;

  hazard_unit dut (
    .clk             (clk),
    .reset           (reset),
    .id_opcode       (id_opcode),
    .id_rs1          (id_rs1),
    .id_rs2          (id_rs2),
    .ex_memread      (ex_memread),
    .ex_rd           (ex_rd),
    .ex_branch_taken (ex_branch_taken),
    .mem_busy        (mem_busy),
    .pc_write        (pc_write),
    .if_id_write     (if_id_write),
    .control_sel     (control_sel),
    .if_id_flush     (if_id_flush),
    .stall_cnt       (stall_cnt),
    .flush_cnt       (flush_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [6:0] op;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       mr;
    logic [4:0] rd;
    logic       br;
    logic       busy;
    logic [3:0] exp;   // {pc_write, if_id_write, control_sel, if_id_flush}
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_out(input string nm, input logic [3:0] exp);
    chk(nm, {28'd0, pc_write, if_id_write, control_sel, if_id_flush}, {28'd0, exp});
  endtask

  task automatic chk_cnt(input string nm, input logic [31:0] st, input logic [31:0] fl);
    chk({nm, "_stall_cnt"}, stall_cnt, PERF ? st : 32'd0);
    chk({nm, "_flush_cnt"}, flush_cnt, PERF ? fl : 32'd0);
  endtask

  task automatic drv(input logic [6:0] op, input logic [4:0] r1, input logic [4:0] r2,
                     input logic mr, input logic [4:0] rd, input logic br, input logic busy);
    id_opcode = op; id_rs1 = r1; id_rs2 = r2;
    ex_memread = mr; ex_rd = rd; ex_branch_taken = br; mem_busy = busy;
  endtask

  // Asynchronous reset pulse placed mid-cycle, away from any clock edge.
  task automatic pulse_reset();
    reset = 1'b1;
    #1;
    reset = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  function automatic bit uses_rs1(input logic [6:0] op);
    return op inside {OP_R, OP_I, OP_LW, OP_SW, OP_BEQ};
  endfunction

  function automatic bit uses_rs2(input logic [6:0] op);
    return op inside {OP_R, OP_SW, OP_BEQ};
  endfunction

  vec_t vecs[$];
  logic [6:0] ops[8];

  initial begin
    bit          owed;
    logic [31:0] m_stall;
    logic [31:0] m_flush;
    logic [3:0]  exp;
    bit          lu;

    vecs.push_back('{OP_R,   5'd5, 5'd1, 1'b1, 5'd5, 1'b0, 1'b0, 4'b0010});
    vecs.push_back('{OP_R,   5'd1, 5'd5, 1'b1, 5'd5, 1'b0, 1'b0, 4'b0010});
    vecs.push_back('{OP_I,   5'd1, 5'd5, 1'b1, 5'd5, 1'b0, 1'b0, 4'b1100});
    vecs.push_back('{OP_I,   5'd5, 5'd1, 1'b1, 5'd5, 1'b0, 1'b0, 4'b0010});
    vecs.push_back('{OP_LW,  5'd7, 5'd7, 1'b1, 5'd7, 1'b0, 1'b0, 4'b0010});
    vecs.push_back('{OP_SW,  5'd2, 5'd9, 1'b1, 5'd9, 1'b0, 1'b0, 4'b0010});
    vecs.push_back('{OP_BEQ, 5'd3, 5'd4, 1'b1, 5'd4, 1'b0, 1'b0, 4'b0010});
    vecs.push_back('{OP_NOP, 5'd5, 5'd5, 1'b1, 5'd5, 1'b0, 1'b0, 4'b1100});
    vecs.push_back('{7'h7F,  5'd5, 5'd5, 1'b1, 5'd5, 1'b0, 1'b0, 4'b1100});
    vecs.push_back('{OP_R,   5'd0, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0, 4'b1100});
    vecs.push_back('{OP_R,   5'd5, 5'd5, 1'b0, 5'd5, 1'b0, 1'b0, 4'b1100});
    vecs.push_back('{OP_R,   5'd5, 5'd1, 1'b1, 5'd5, 1'b1, 1'b0, 4'b1111});
    vecs.push_back('{OP_R,   5'd5, 5'd1, 1'b1, 5'd5, 1'b1, 1'b1, 4'b0000});
    vecs.push_back('{OP_R,   5'd5, 5'd1, 1'b0, 5'd6, 1'b0, 1'b1, 4'b0000});
    vecs.push_back('{OP_R,   5'd1, 5'd2, 1'b0, 5'd0, 1'b1, 1'b0, 4'b1111});

    ops = '{OP_NOP, OP_R, OP_I, OP_LW, OP_SW, OP_BEQ, 7'h33, 7'h00};

    // Reset values, with a load-use pattern present to show reset dominates.
    drv(OP_R, 5'd5, 5'd1, 1'b1, 5'd5, 1'b0, 1'b0);
    #2;
    chk_out("reset_outputs", 4'b1100);
    chk_cnt("reset", 32'd0, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    foreach (vecs[i]) begin
      @(negedge clk);
      pulse_reset();
      drv(vecs[i].op, vecs[i].rs1, vecs[i].rs2, vecs[i].mr, vecs[i].rd, vecs[i].br, vecs[i].busy);
      #1;
      chk_out($sformatf("vec%0d", i), vecs[i].exp);
    end

    // LW x5 then ADD x6,x5,x1: one bubble cycle then STALL.
    next_cycle();
    pulse_reset();
    drv(OP_R, 5'd5, 5'd1, 1'b1, 5'd5, 1'b0, 1'b0);
    #1;
    chk_out("lu_bubble", 4'b0010);
    next_cycle();
    chk_out("lu_stall_state", 4'b1100);
    chk_cnt("lu", 32'd1, 32'd0);
    next_cycle();
    chk_out("lu_back_to_run", 4'b0010);
    drv(OP_NOP, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);

    // ex_rd = x0 never stalls.
    next_cycle();
    pulse_reset();
    drv(OP_R, 5'd0, 5'd3, 1'b1, 5'd0, 1'b0, 1'b0);
    #1;
    chk_out("rd_zero", 4'b1100);
    next_cycle();
    chk_out("rd_zero_next", 4'b1100);
    chk_cnt("rd_zero", 32'd0, 32'd0);

    // ADDI ignores rs2.
    drv(OP_I, 5'd1, 5'd5, 1'b1, 5'd5, 1'b0, 1'b0);
    #1;
    chk_out("addi_rs2", 4'b1100);

    // Branch beats a simultaneous load-use.
    next_cycle();
    pulse_reset();
    drv(OP_R, 5'd5, 5'd1, 1'b1, 5'd5, 1'b1, 1'b0);
    #1;
    chk_out("br_over_lu", 4'b1111);
    next_cycle();
    chk_cnt("br_over_lu", 32'd0, 32'd1);
    drv(OP_NOP, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    #1;
    chk_out("br_after", 4'b1100);

    // mem_busy for 3 cycles in the middle of a stall.
    next_cycle();
    pulse_reset();
    drv(OP_R, 5'd5, 5'd1, 1'b1, 5'd5, 1'b0, 1'b0);
    #1;
    chk_out("hold_bubble", 4'b0010);
    for (int k = 0; k < 3; k++) begin
      next_cycle();
      mem_busy = 1'b1;
      #1;
      chk_out($sformatf("hold_busy%0d", k), 4'b0000);
    end
    next_cycle();
    mem_busy = 1'b0;
    #1;
    chk_out("hold_resume_stall", 4'b1100);
    next_cycle();
    ex_memread = 1'b0;
    #1;
    chk_out("hold_run", 4'b1100);
    chk_cnt("hold", 32'd4, 32'd0);

    // Branch taken while in STALL flushes.
    next_cycle();
    pulse_reset();
    drv(OP_R, 5'd5, 5'd1, 1'b1, 5'd5, 1'b0, 1'b0);
    next_cycle();
    ex_branch_taken = 1'b1;
    #1;
    chk_out("stall_branch", 4'b1111);
    next_cycle();
    drv(OP_NOP, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    #1;
    chk_out("stall_branch_run", 4'b1100);
    chk_cnt("stall_branch", 32'd1, 32'd1);

    // Reset in STALL and in HOLD acts without a clock edge.
    next_cycle();
    pulse_reset();
    drv(OP_R, 5'd5, 5'd1, 1'b1, 5'd5, 1'b0, 1'b0);
    next_cycle();
    #1;
    reset = 1'b1;
    #1;
    chk_out("rst_in_stall", 4'b1100);
    chk_cnt("rst_in_stall", 32'd0, 32'd0);
    reset = 1'b0;
    #1;
    chk_out("rst_in_stall_run", 4'b0010);
    next_cycle();
    mem_busy = 1'b1;
    next_cycle();
    #1;
    reset = 1'b1;
    #1;
    chk_out("rst_in_hold", 4'b1100);
    chk_cnt("rst_in_hold", 32'd0, 32'd0);
    drv(OP_NOP, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    reset = 1'b0;

    // Randomized traffic against the reference model.
    next_cycle();
    pulse_reset();
    owed = 1'b0;
    m_stall = 32'd0;
    m_flush = 32'd0;
    for (int c = 0; c < 3000; c++) begin
      next_cycle();
      if ($urandom_range(0, 59) == 0) begin
        reset = 1'b1;
        #1;
        chk_out("rnd_reset", 4'b1100);
        chk_cnt("rnd_reset", 32'd0, 32'd0);
        reset = 1'b0;
        owed = 1'b0;
        m_stall = 32'd0;
        m_flush = 32'd0;
      end
      drv(ops[$urandom_range(0, 7)], 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
          1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
          ($urandom_range(0, 6) == 0), ($urandom_range(0, 3) == 0));
      #3;
      lu = ex_memread && ex_rd != 0 &&
           ((uses_rs1(id_opcode) && id_rs1 == ex_rd) || (uses_rs2(id_opcode) && id_rs2 == ex_rd));
      if (mem_busy) begin
        exp = 4'b0000;
      end else if (owed) begin
        exp = ex_branch_taken ? 4'b1111 : 4'b1100;
        owed = 1'b0;
      end else if (ex_branch_taken) begin
        exp = 4'b1111;
      end else if (lu) begin
        exp = 4'b0010;
        owed = 1'b1;
      end else begin
        exp = 4'b1100;
      end
      chk_out($sformatf("rnd%0d", c), exp);
      chk_cnt($sformatf("rnd%0d", c), m_stall, m_flush);
      if (!exp[3]) m_stall = m_stall + 32'd1;
      if (exp[0]) m_flush = m_flush + 32'd1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
